pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
// - Input-capture peripheral; the receive side of the PWM path. Measures the period and the
//   active-phase width of an external PWM signal in clk cycles.
// - Sits beside the PWM generator in the timer subsystem. Results go to the register file.
// - Bench loopback: the generator's pwm_out feeds this block's pwm_in.
// PARAMETERS
// - CNT_W        16  width of the measurement counter and of both results
// - SYNC_STAGES  2   flops in the pwm_in synchroniser chain (>=2)
// PORTS
// - clk         in   1      clock
// - rst_n       in   1      asynchronous, active-low reset
// - cap_en      in   1      1 = capture enabled; 0 = return to IDLE
// - polarity    in   1      0 = active-high input; 1 = active-low (input inverted before edge detect)
// - timeout     in   CNT_W  signal-lost limit in cycles; 0 = disabled
// - pwm_in      in   1      asynchronous PWM input
// - period_out  out  CNT_W  last measured period (active edge to active edge)
// - high_out    out  CNT_W  last measured active-phase width
// - cap_valid   out  1      1-cycle pulse: new period_out/high_out pair
// - cap_ovf     out  1      qualifies the current pair: a count saturated
// - sig_lost    out  1      level: no edge within timeout
// - busy        out  1      state not IDLE
// BEHAVIOUR
// - Reset values: all outputs 0, synchroniser flops 0, cnt 0, state IDLE.
// - s = synchronised pwm_in XOR polarity.
// - rise/fall = s vs its 1-cycle-delayed copy; that cycle is the "detection cycle".
// - Synchroniser and edge detector run regardless of cap_en.
// - Counter cnt: loaded with 1 on the clock after any rise detection. Otherwise it increments
//   and saturates at 2^CNT_W-1. A saturation sets an internal ovf flag, cleared on each rise.
// - Result: a high phase of H cycles and period P yields high_out=H, period_out=P.
// - FSM states: IDLE, WAIT_LOW, WAIT_RISE, HIGH, LOW.
//   - IDLE: cap_en=1 -> WAIT_LOW.
//   - WAIT_LOW: s==0 -> WAIT_RISE. This discards a partial first phase, e.g. when s is high
//     at enable or after reset.
//   - WAIT_RISE: rise -> HIGH (cnt<=1, ovf<=0).
//   - HIGH: fall -> LOW; high_cap<=cnt.
//   - LOW: rise -> HIGH (cnt<=1).
//     - On the same edge: period_out<=cnt, high_out<=high_cap, cap_ovf<=ovf, cap_valid<=1.
//     - Back-to-back periods are measured with no gap.
// - cap_valid is high exactly one cycle after the closing rise is detected.
//   period_out/high_out/cap_ovf change only on that edge and hold otherwise.
// - Timeout: if timeout!=0 and cnt==timeout in HIGH or LOW -> WAIT_LOW, sig_lost<=1, no cap_valid.
//   - sig_lost clears on the next cap_valid or on cap_en=0.
//   - An edge and a timeout in the same cycle: the edge wins.
// - cap_en=0 in any state -> IDLE on the next clock.
//   - cnt cleared, sig_lost cleared, no cap_valid.
//   - period_out/high_out/cap_ovf keep their last values.
// - polarity and timeout are changed only while cap_en=0. Changing them while enabled is
//   outside the spec.
// - Asynchronous reset mid-measurement: everything returns to reset values immediately.
// - Latency from a pwm_in transition to its detection cycle: SYNC_STAGES+1 clk.
// STRUCTURE
// - pwm_pkg holds the FSM state encodings, CNT_W_DEF=16 and SYNC_STAGES_DEF=2.
//   The package is shared with pwm_gen's register map.
// - Sub-module pwm_in_sync contains the SYNC_STAGES synchroniser, the polarity XOR and the
//   rise/fall detector. Outputs: s, rise, fall.
// - Top level: FSM, counter, high_cap and output registers.
// TESTING
// - T1: polarity=0, pwm_in high 3 / low 7, cap_en=1
//   -> first cap_valid after one full period is discarded by WAIT_LOW/WAIT_RISE.
//   -> then cap_valid every 10 cycles, period_out=10, high_out=3, cap_ovf=0.
// - T2: polarity=1, pwm_in low 2 / high 6
//   -> period_out=8, high_out=2.
//   -> cap_en toggled 0->1 while pwm_in is low: no capture until a full low phase follows a high phase.
// - T3: timeout=20, pwm_in rises then stays high
//   -> sig_lost=1 on the clock where cnt==20 (20 cycles after the rise detection cycle), no cap_valid.
//   -> resume 4/10 PWM: sig_lost stays 1 until the first cap_valid, which shows period_out=10,
//      high_out=4 and clears sig_lost.
// - T4: CNT_W=8, timeout=0, high 300 / low 10
//   -> cap_valid with high_out=255, period_out=255, cap_ovf=1.
//   -> next period 5/5 gives cap_ovf=0, high_out=5, period_out=10.
// - T5: cap_en dropped mid-HIGH
//   -> busy=0 one cycle later, no cap_valid, period_out/high_out unchanged.
//   -> rst_n pulsed mid-LOW: all outputs 0 at once.
// - T6: loopback from pwm_gen, period=9, functions=00, compare1=4
//   -> period_out=10 on every cap_valid, cap_ovf=0, sig_lost=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared timer-subsystem constants and capture FSM state encoding
package pwm_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
  typedef enum logic [2:0] {IDLE, WAIT_LOW, WAIT_RISE, HIGH, LOW} cap_state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: configuration, PWM input and measurement results of the capture block
interface pwm_capture_if import pwm_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
);
  logic cap_en;
  logic polarity;
  logic pwm_in;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic cap_valid;
  logic cap_ovf;
  logic sig_lost;
  logic busy;
  modport master (
    output cap_en, polarity, pwm_in, timeout,
    input period_out, high_out, cap_valid, cap_ovf, sig_lost, busy
  );
  modport slave (
    input cap_en, polarity, pwm_in, timeout,
    output period_out, high_out, cap_valid, cap_ovf, sig_lost, busy
  );
endinterface

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: synchronises pwm_in, applies polarity and detects rise/fall of the active level
module pwm_in_sync import pwm_pkg::*; #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  input  logic polarity,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic s_d;
  // s is registered after the XOR so a transition reaches its detection cycle SYNC_STAGES+1 clocks later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      s <= 1'b0;
      s_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s <= sync[SYNC_STAGES-1] ^ polarity;
      s_d <= s;
    end
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and active-phase width of an external PWM input in clk cycles
module pwm_capture import pwm_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic clk,
  input logic rst_n,
  pwm_capture_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  cap_state_t state;
  logic s, rise, fall, ovf, tmo;
  logic [CNT_W-1:0] cnt, high_cap;
  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(bus.pwm_in),
    .polarity(bus.polarity),
    .s(s),
    .rise(rise),
    .fall(fall)
  );
  assign tmo = (bus.timeout != '0) && (cnt == bus.timeout);
  // cnt restarts on every rise so it reads the elapsed time since the opening edge in HIGH and LOW
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ovf <= 1'b0;
      high_cap <= '0;
      bus.period_out <= '0;
      bus.high_out <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_ovf <= 1'b0;
      bus.sig_lost <= 1'b0;
      bus.busy <= 1'b0;
    end else if (!bus.cap_en) begin
      state <= IDLE;
      cnt <= '0;
      bus.cap_valid <= 1'b0;
      bus.sig_lost <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.cap_valid <= 1'b0;
      bus.busy <= 1'b1;
      cnt <= rise ? CNT_ONE : (cnt == CNT_MAX ? cnt : cnt + CNT_ONE);
      ovf <= rise ? 1'b0 : (ovf | (cnt == CNT_MAX));
      case (state)
        IDLE: state <= WAIT_LOW;
        WAIT_LOW: state <= s ? WAIT_LOW : WAIT_RISE;
        WAIT_RISE: state <= rise ? HIGH : WAIT_RISE;
        HIGH:
          if (fall) begin
            state <= LOW;
            high_cap <= cnt;
          end else if (tmo) begin
            state <= WAIT_LOW;
            bus.sig_lost <= 1'b1;
          end
        LOW:
          if (rise) begin
            state <= HIGH;
            bus.period_out <= cnt;
            bus.high_out <= high_cap;
            bus.cap_ovf <= ovf;
            bus.cap_valid <= 1'b1;
            bus.sig_lost <= 1'b0;
          end else if (tmo) begin
            state <= WAIT_LOW;
            bus.sig_lost <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives a 16-bit and an 8-bit capture block with the same PWM stimulus and checks both
module tb_pwm_capture;
  logic clk = 1'b0;
  logic rst_n, cap_en, polarity, pwm_in, gen_on;
  logic [15:0] timeout;
  int hi_len, lo_len, gph;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(16)) b16 ();
  pwm_capture_if #(.CNT_W(8)) b8 ();
  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  assign b16.cap_en = cap_en;
  assign b16.polarity = polarity;
  assign b16.pwm_in = pwm_in;
  assign b16.timeout = timeout;
  assign b8.cap_en = cap_en;
  assign b8.polarity = polarity;
  assign b8.pwm_in = pwm_in;
  assign b8.timeout = timeout[7:0];

  logic [31:0] d_per[2], d_high[2], d_val[2], d_ovf[2], d_lost[2], d_busy[2];
  assign d_per[0] = 32'(b16.period_out);
  assign d_per[1] = 32'(b8.period_out);
  assign d_high[0] = 32'(b16.high_out);
  assign d_high[1] = 32'(b8.high_out);
  assign d_val[0] = 32'(b16.cap_valid);
  assign d_val[1] = 32'(b8.cap_valid);
  assign d_ovf[0] = 32'(b16.cap_ovf);
  assign d_ovf[1] = 32'(b8.cap_ovf);
  assign d_lost[0] = 32'(b16.sig_lost);
  assign d_lost[1] = 32'(b8.sig_lost);
  assign d_busy[0] = 32'(b16.busy);
  assign d_busy[1] = 32'(b8.busy);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int lim, output int k);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!b16.cap_valid && k < lim);
    chk("wait_valid", 32'(b16.cap_valid), 1);
  endtask

  // PWM source: pwm_in high for hi_len cycles then low for lo_len, phase gph
  initial forever begin
    @(posedge clk);
    #1;
    if (gen_on) begin
      pwm_in = gph < hi_len;
      gph = (gph + 1 >= hi_len + lo_len) ? 0 : gph + 1;
    end
  end

  // Model: measurement described by timestamps of detected edges of the delayed, polarity-corrected input
  logic [4:0] hx;
  logic ms, mr, mf;
  int mode[2], t_rise[2], t_fall[2];
  int n = 0;
  logic [31:0] e_per[2], e_high[2], e_val[2], e_ovf[2], e_lost[2], e_busy[2];
  always @(negedge clk) begin
    if (!rst_n) begin
      hx = '0;
      for (int i = 0; i < 2; i++) begin
        mode[i] = 0;
        e_per[i] = 0;
        e_high[i] = 0;
        e_val[i] = 0;
        e_ovf[i] = 0;
        e_lost[i] = 0;
        e_busy[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk(i ? "m8_period" : "m16_period", d_per[i], e_per[i]);
      chk(i ? "m8_high" : "m16_high", d_high[i], e_high[i]);
      chk(i ? "m8_valid" : "m16_valid", d_val[i], e_val[i]);
      chk(i ? "m8_ovf" : "m16_ovf", d_ovf[i], e_ovf[i]);
      chk(i ? "m8_lost" : "m16_lost", d_lost[i], e_lost[i]);
      chk(i ? "m8_busy" : "m16_busy", d_busy[i], e_busy[i]);
    end
    if (rst_n) begin
      hx = {hx[3:0], pwm_in};
      ms = hx[3] ^ polarity;
      mr = ms & ~(hx[4] ^ polarity);
      mf = ~ms & (hx[4] ^ polarity);
      for (int i = 0; i < 2; i++) begin
        int mx, tmo, p, h, el;
        mx = i ? 255 : 65535;
        tmo = int'(timeout) & mx;
        el = (n - t_rise[i] > mx) ? mx : n - t_rise[i];
        e_val[i] = 0;
        e_busy[i] = 32'(cap_en);
        if (!cap_en) begin
          mode[i] = 0;
          e_lost[i] = 0;
        end else if (mode[i] == 0) mode[i] = 1;
        else if (mode[i] == 1) begin
          if (!ms) mode[i] = 2;
        end else if (mode[i] == 2) begin
          if (mr) begin
            mode[i] = 3;
            t_rise[i] = n;
            t_fall[i] = -1;
          end
        end else if (mr) begin
          p = n - t_rise[i];
          h = t_fall[i] - t_rise[i];
          e_per[i] = 32'(p > mx ? mx : p);
          e_high[i] = 32'(h > mx ? mx : h);
          e_ovf[i] = 32'(p > mx);
          e_val[i] = 1;
          e_lost[i] = 0;
          t_rise[i] = n;
          t_fall[i] = -1;
        end else if (mf) t_fall[i] = n;
        else if (tmo != 0 && el == tmo) begin
          mode[i] = 1;
          e_lost[i] = 1;
        end
      end
    end
    n++;
  end

  initial begin
    int k;
    logic drop;
    rst_n = 1'b0;
    cap_en = 1'b0;
    polarity = 1'b0;
    timeout = '0;
    pwm_in = 1'b0;
    gen_on = 1'b0;
    hi_len = 1;
    lo_len = 1;
    gph = 0;
    tick(3);
    chk("rst_busy", d_busy[0], 0);
    chk("rst_period", d_per[0], 0);
    chk("rst_valid", d_val[0], 0);
    rst_n = 1'b1;
    tick(2);
    // T1: 3 high / 7 low
    hi_len = 3;
    lo_len = 7;
    gph = 0;
    gen_on = 1'b1;
    tick(2);
    cap_en = 1'b1;
    wait_valid(40, k);
    chk("t1_period", d_per[0], 10);
    chk("t1_high", d_high[0], 3);
    chk("t1_ovf", d_ovf[0], 0);
    repeat (3) begin
      wait_valid(20, k);
      chk("t1_gap", 32'(k), 10);
      chk("t1_period_n", d_per[0], 10);
      chk("t1_high_n", d_high[0], 3);
    end
    // T2: active-low, low 2 / high 6
    cap_en = 1'b0;
    polarity = 1'b1;
    hi_len = 6;
    lo_len = 2;
    gph = 0;
    tick(6);
    cap_en = 1'b1;
    wait_valid(40, k);
    chk("t2_period", d_per[0], 8);
    chk("t2_high", d_high[0], 2);
    k = 0;
    do begin tick(1); k++; end while (!pwm_in && k < 20);
    k = 0;
    do begin tick(1); k++; end while (pwm_in && k < 20);
    cap_en = 1'b0;
    tick(1);
    cap_en = 1'b1;
    wait_valid(40, k);
    chk("t2_reenable_lat", 32'(k), 11);
    chk("t2_period_re", d_per[0], 8);
    chk("t2_high_re", d_high[0], 2);
    // T3: timeout 20, input stuck high
    cap_en = 1'b0;
    polarity = 1'b0;
    gen_on = 1'b0;
    pwm_in = 1'b0;
    timeout = 16'd20;
    tick(6);
    cap_en = 1'b1;
    tick(6);
    pwm_in = 1'b1;
    tick(23);
    chk("t3_lost_pre", d_lost[0], 0);
    tick(1);
    chk("t3_lost", d_lost[0], 1);
    chk("t3_lost8", d_lost[1], 1);
    hi_len = 4;
    lo_len = 6;
    gph = 0;
    gen_on = 1'b1;
    k = 0;
    drop = 1'b0;
    do begin
      tick(1);
      k++;
      if (!b16.cap_valid && !b16.sig_lost) drop = 1'b1;
    end while (!b16.cap_valid && k < 60);
    chk("t3_lost_held", 32'(drop), 0);
    chk("t3_valid", d_val[0], 1);
    chk("t3_period", d_per[0], 10);
    chk("t3_high", d_high[0], 4);
    chk("t3_lost_clr", d_lost[0], 0);
    // T4: 300 high / 10 low saturates the 8-bit instance
    cap_en = 1'b0;
    timeout = '0;
    hi_len = 300;
    lo_len = 10;
    gph = 0;
    tick(4);
    cap_en = 1'b1;
    wait_valid(1000, k);
    chk("t4_period8", d_per[1], 255);
    chk("t4_high8", d_high[1], 255);
    chk("t4_ovf8", d_ovf[1], 1);
    chk("t4_period16", d_per[0], 310);
    chk("t4_high16", d_high[0], 300);
    chk("t4_ovf16", d_ovf[0], 0);
    hi_len = 5;
    lo_len = 5;
    gph = 0;
    wait_valid(40, k);
    wait_valid(20, k);
    chk("t4_period8_b", d_per[1], 10);
    chk("t4_high8_b", d_high[1], 5);
    chk("t4_ovf8_b", d_ovf[1], 0);
    // T5: disable mid-HIGH, then reset mid-LOW
    wait_valid(20, k);
    cap_en = 1'b0;
    tick(1);
    chk("t5_busy_off", d_busy[0], 0);
    k = 0;
    repeat (15) begin
      tick(1);
      if (b16.cap_valid) k++;
    end
    chk("t5_no_valid", 32'(k), 0);
    chk("t5_period_hold", d_per[0], 10);
    chk("t5_high_hold", d_high[0], 5);
    cap_en = 1'b1;
    wait_valid(40, k);
    tick(6);
    rst_n = 1'b0;
    cap_en = 1'b0;
    #1;
    chk("t5_rst_period", d_per[0], 0);
    chk("t5_rst_high", d_high[0], 0);
    chk("t5_rst_busy", d_busy[0], 0);
    chk("t5_rst_period8", d_per[1], 0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    // T6: stands in for pwm_gen loopback with period=9, compare1=4 (10-cycle frame, 4 active)
    hi_len = 4;
    lo_len = 6;
    gph = 0;
    cap_en = 1'b1;
    wait_valid(40, k);
    repeat (4) begin
      wait_valid(20, k);
      chk("t6_gap", 32'(k), 10);
      chk("t6_period", d_per[0], 10);
      chk("t6_ovf", d_ovf[0], 0);
      chk("t6_lost", d_lost[0], 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
